room_sequencer: RTL

ROOM_SEQUENCER -- requirements
Module: room_sequencer

---
 rtl/room_pkg.sv | 50 +++++
 rtl/room_map_lookup.sv | 21 ++
 rtl/room_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/room_pkg.sv
// Shared types and the default room map for the room transition sequencer.
package room_pkg;

  typedef enum logic [2:0] {
    DOOR_NONE   = 3'd0,
    DOOR_LEFT   = 3'd1,
    DOOR_RIGHT  = 3'd2,
    DOOR_TOP    = 3'd3,
    DOOR_BOTTOM = 3'd4
  } door_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_LOAD     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_e;

  localparam int         MAP_ROOMS = 8;
  localparam logic [7:0] NO_EXIT   = 8'hFF;

  // One byte per (room, door), entry index room*4 + door-1, same layout as the lock mask.
  // Listed from room 7 down to room 0, each as {bottom, top, right, left}.
  localparam logic [MAP_ROOMS*4*8-1:0] DEFAULT_MAP = {
    NO_EXIT, NO_EXIT, NO_EXIT, 8'd5,     // room 7
    8'd5,    NO_EXIT, NO_EXIT, NO_EXIT,  // room 6
    NO_EXIT, 8'd6,    8'd7,    8'd4,     // room 5
    NO_EXIT, 8'd3,    8'd5,    NO_EXIT,  // room 4
    8'd4,    NO_EXIT, NO_EXIT, 8'd1,     // room 3
    8'd0,    NO_EXIT, NO_EXIT, NO_EXIT,  // room 2
    NO_EXIT, NO_EXIT, 8'd3,    8'd0,     // room 1
    NO_EXIT, 8'd2,    8'd1,    NO_EXIT   // room 0
  };

  function automatic logic [7:0] map_target(input int rm, input int door);
    if (rm < 0 || rm >= MAP_ROOMS || door < 1 || door > 4) return NO_EXIT;
    return DEFAULT_MAP[(rm*4 + door - 1)*8 +: 8];
  endfunction

  function automatic logic [2:0] opposite_door(input logic [2:0] door);
    case (door)
      DOOR_LEFT:   return DOOR_RIGHT;
      DOOR_RIGHT:  return DOOR_LEFT;
      DOOR_TOP:    return DOOR_BOTTOM;
      DOOR_BOTTOM: return DOOR_TOP;
      default:     return DOOR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/room_map_lookup.sv
// Combinational map lookup: (room, doorcode) -> target room, or NO_EXIT.
module room_map_lookup
  import room_pkg::*;
#(
  parameter int NUM_ROOMS = 8,
  parameter int ROOM_W    = $clog2(NUM_ROOMS)
) (
  input  logic [ROOM_W-1:0] room,
  input  logic [2:0]        doorcode,
  output logic [7:0]        target
);

  logic [7:0] code;

  // Targets beyond the configured room count are treated as walls.
  always_comb begin
    code   = map_target(int'(room), int'(doorcode));
    target = (code != NO_EXIT && int'(code) < NUM_ROOMS) ? code : NO_EXIT;
  end

endmodule

// File: rtl/room_sequencer.sv
// Room transition sequencer: door lookup, lock mask, fade-out / load / fade-in
// timed on vsync. The FSM state is exported on the state port for observation.
module room_sequencer
  import room_pkg::*;
#(
  parameter int NUM_ROOMS    = 8,
  parameter int TRANS_FRAMES = 16,
  parameter logic [NUM_ROOMS*4-1:0] LOCK_INIT =
    {{(NUM_ROOMS*4-1){1'b0}}, 1'b1} << (5*4 + 1),
  localparam int ROOM_W = $clog2(NUM_ROOMS),
  localparam int LVL_W  = $clog2(TRANS_FRAMES + 1)
) (
  input  logic              vsync,
  input  logic              Reset,
  input  logic [2:0]        doorcode,
  input  logic              unlock_valid,
  input  logic [ROOM_W-1:0] unlock_room,
  input  logic [2:0]        unlock_door,
  output logic [ROOM_W-1:0] room,
  output logic              initialize_room,
  output logic [2:0]        spawn_side,
  output logic [LVL_W-1:0]  fade_level,
  output logic              busy,
  output state_e            state
);

  localparam logic [LVL_W-1:0] FULL = LVL_W'(TRANS_FRAMES);

  logic [7:0]             map_code;
  logic [ROOM_W-1:0]      target_q;
  logic [NUM_ROOMS*4-1:0] lock_mask;
  logic [NUM_ROOMS*4-1:0] req_sel;
  logic [NUM_ROOMS*4-1:0] unlock_sel;
  int                     req_idx;
  int                     unlock_idx;
  logic                   unlock_ok;
  logic                   door_is_move;
  logic                   door_locked;
  logic                   req_ok;

  room_map_lookup #(
    .NUM_ROOMS (NUM_ROOMS),
    .ROOM_W    (ROOM_W)
  ) u_lookup (
    .room     (room),
    .doorcode (doorcode),
    .target   (map_code)
  );

  // Requests see the registered lock mask, so an unlock in the same frame
  // only takes effect for later requests.
  always_comb begin
    req_idx      = int'(room) * 4 + int'(doorcode) - 1;
    unlock_idx   = int'(unlock_room) * 4 + int'(unlock_door) - 1;
    door_is_move = (doorcode >= 3'd1) && (doorcode <= 3'd4);
    unlock_ok    = unlock_valid && (int'(unlock_room) < NUM_ROOMS) &&
                   (unlock_door >= 3'd1) && (unlock_door <= 3'd4);
    for (int i = 0; i < NUM_ROOMS*4; i++) begin
      req_sel[i]    = (i == req_idx);
      unlock_sel[i] = unlock_ok && (i == unlock_idx);
    end
    door_locked = |(lock_mask & req_sel);
    req_ok      = (state == ST_IDLE) && door_is_move &&
                  (map_code != NO_EXIT) && !door_locked;
  end

  always_ff @(posedge vsync) begin
    if (!Reset) begin
      state           <= ST_IDLE;
      room            <= '0;
      target_q        <= '0;
      spawn_side      <= 3'd0;
      fade_level      <= FULL;
      busy            <= 1'b0;
      lock_mask       <= LOCK_INIT;
      initialize_room <= 1'b1;
    end else begin
      lock_mask       <= lock_mask & ~unlock_sel;
      initialize_room <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            target_q   <= map_code[ROOM_W-1:0];
            spawn_side <= opposite_door(doorcode);
            busy       <= 1'b1;
            state      <= ST_FADE_OUT;
          end
        end
        ST_FADE_OUT: begin
          if (fade_level <= LVL_W'(1)) begin
            fade_level <= '0;
            state      <= ST_LOAD;
          end else begin
            fade_level <= fade_level - LVL_W'(1);
          end
        end
        ST_LOAD: begin
          room            <= target_q;
          initialize_room <= 1'b1;
          state           <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          // Full brightness is shown for one frame before movement is released.
          if (fade_level >= FULL) begin
            fade_level <= FULL;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            fade_level <= fade_level + LVL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
